aes128_encrypt_core: RTL and testbench
======================================

Name: aes128_encrypt_core

Overview:
Iterative AES-128 encryption engine (FIPS-197, encrypt direction only) with a fixed, parameter-supplied cipher key. It accepts one 128-bit plaintext block per transaction, runs one round per enabled clock, and presents the ciphertext with a one-cycle valid strobe. It is a self-contained crypto leaf with no external key port.

Parameters:
KEY, 128'h000102030405060708090A0B0C0D0E0F, fixed AES-128 cipher key; bit 0 is the MSB and KEY[0:7] is key byte 0.

Ports:
clk  input  1  rising-edge clock, the only clock domain
reset  input  1  synchronous, active-high reset
enable  input  1  clock enable; when 0 the core stalls
Din  input  128 [0:127]  plaintext; Din[0:7] is state byte 0 (column-major, FIPS order)
Din_valid  input  1  plaintext request, sampled on enabled edges
Dout  output  128 [0:127]  ciphertext, same byte ordering as Din
Dout_valid  output  1  one-cycle strobe marking a new Dout

Behaviour:
- Reset: one clock, synchronous and active-high. On a rising edge with reset=1: Dout=0, Dout_valid=0, busy=0, round counter=0, round key=KEY. Reset takes priority over enable and aborts any block in flight; no output is produced for an aborted block.
- Stall: on an edge with enable=0 and reset=0, all registers hold, except Dout_valid, which is forced to 0. Dout_valid is only ever high following an enabled edge.
- States: IDLE (busy=0) and RUN (busy=1, round counter r=1..10).
- IDLE: on an enabled edge with Din_valid=1, the core loads state = Din XOR KEY, round key = KEY, sets r=1 and busy=1, and moves to RUN. With Din_valid=0 it stays in IDLE.
- RUN: each enabled edge performs round r using an on-the-fly round key.
  - Round key: RK_r = expand(RK_{r-1}) with RotWord, SubWord and Rcon = 01,02,04,08,10,20,40,80,1B,36 for r=1..10.
  - Rounds 1-9: SubBytes, ShiftRows, MixColumns (GF(2^8), polynomial 0x11B), then AddRoundKey(RK_r).
  - Round 10: SubBytes, ShiftRows, AddRoundKey(RK_10), with no MixColumns.
- Completion: on the round-10 edge, Dout is loaded with the result, Dout_valid=1 for exactly one cycle, and the core returns to IDLE.
- Latency: the capture edge is N. With enable held at 1, the result and Dout_valid are visible after edge N+10. The next block can be captured at edge N+11. Stalled edges add one cycle each.
- Din_valid while busy is ignored. The request is not queued and there is no backpressure output. A Din_valid held high for several cycles starts one block, and then starts another once the core is IDLE again if it is still high.
- Dout holds the last ciphertext until the next completion or reset.
- Din is sampled only on the capture edge; later changes to Din do not affect the block in flight.
- S-box: the standard forward AES S-box, implemented combinationally as a function or LUT. It is used by 16 state lanes and 4 key-schedule lanes.
- No X on outputs after the first reset edge.

Test Plan:
- FIPS-197 C.1 vector: default KEY, reset then enable=1, Din=00112233445566778899AABBCCDDEEFF with a 1-cycle Din_valid -> Dout=69C4E0D86A7B0430D8CDB78070B4C55A, Dout_valid high for exactly 1 cycle, 10 edges after capture.
- Second vector: default KEY, Din=00112233445566778899AABBCCDDFFF0 with Din_valid held for 2 cycles -> exactly one Dout_valid pulse, Dout=1D3E80EAD35822D3C7694761104A8F87.
- KEY parameter overridden to all zeros, Din=0 -> Dout=66E94BD4EF8A2C3B884CFA59CA342B2E.
- Stall: enable=0 for 3 cycles mid-RUN during vector 1 -> same ciphertext, Dout_valid arrives 3 cycles later, Dout_valid low during the stall cycles.
- Reset mid-operation: reset asserted at round 5 -> Dout=0 and Dout_valid=0 on the next edge, no pulse for the aborted block. A fresh request afterwards gives the correct vector-1 result.
- Back-to-back: Din_valid held high continuously with Din changing every cycle -> a pulse every 11 cycles, each Dout matching the Din present at its capture edge; inputs during RUN are ignored.

Source files
------------

// File: rtl/aes128_encrypt_core.sv
// aes128_encrypt_core: iterative AES-128 encryptor with a fixed cipher key.
// Each enabled clock runs one round. The round key is expanded on the fly
// from the previous round key.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   enable     clock enable; a low enable stalls the core
//   Din        plaintext [0:127], Din[0:7] = state byte 0 (column-major)
//   Din_valid  start request, accepted only while idle
//   Dout       ciphertext, same byte ordering; holds until the next result
//   Dout_valid one-cycle strobe on each new Dout

// Forward AES S-box lane, realised as a combinational table lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = SBOX[{a, 3'b000} +: 8];
endmodule

module aes128_encrypt_core #(
  parameter logic [0:127] KEY = 128'h000102030405060708090A0B0C0D0E0F
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [0:127] Din,
  input  logic         Din_valid,
  output logic [0:127] Dout,
  output logic         Dout_valid
);
  localparam int NUM_LANES = 16;

  typedef enum logic {IDLE, RUN} fsm_t;
  fsm_t fsm;

  logic [3:0] rnd;
  logic [NUM_LANES-1:0][7:0] st, rk;          // byte i = FIPS state byte i
  logic [NUM_LANES-1:0][7:0] sb_in, sb_out, sr, mc, nrk, nst;
  logic [3:0][7:0] ks_in, ks_out, tw;
  logic [7:0] rcon;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  aes_sbox u_sb [NUM_LANES-1:0] (.a(sb_in), .y(sb_out));
  aes_sbox u_ks [3:0]           (.a(ks_in), .y(ks_out));

  always_comb begin
    case (rnd)
      4'd1: rcon = 8'h01;  4'd2: rcon = 8'h02;  4'd3: rcon = 8'h04;
      4'd4: rcon = 8'h08;  4'd5: rcon = 8'h10;  4'd6: rcon = 8'h20;
      4'd7: rcon = 8'h40;  4'd8: rcon = 8'h80;  4'd9: rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    sb_in = st;
    // ShiftRows: row r of column c comes from column (c+r) mod 4
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb_out[4*((c+r)%4)+r];
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
    // Key schedule: RotWord of the last word feeds the four S-box lanes
    for (int k = 0; k < 4; k++) ks_in[k] = rk[12 + (k+1)%4];
    tw = ks_out;
    tw[0] = ks_out[0] ^ rcon;
    nrk = '0;
    for (int b = 0; b < 4; b++) nrk[b] = rk[b] ^ tw[b];
    for (int w = 1; w < 4; w++)
      for (int b = 0; b < 4; b++)
        nrk[4*w+b] = rk[4*w+b] ^ nrk[4*(w-1)+b];
    for (int i = 0; i < NUM_LANES; i++)
      nst[i] = ((rnd == 4'd10) ? sr[i] : mc[i]) ^ nrk[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      rnd        <= 4'd0;
      st         <= '0;
      for (int i = 0; i < NUM_LANES; i++) rk[i] <= KEY[8*i +: 8];
      Dout       <= '0;
      Dout_valid <= 1'b0;
    end else begin
      Dout_valid <= 1'b0;
      if (enable) begin
        case (fsm)
          IDLE: if (Din_valid) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              st[i] <= Din[8*i +: 8] ^ KEY[8*i +: 8];
              rk[i] <= KEY[8*i +: 8];
            end
            rnd <= 4'd1;
            fsm <= RUN;
          end
          RUN: begin
            st <= nst;
            rk <= nrk;
            if (rnd == 4'd10) begin
              for (int i = 0; i < NUM_LANES; i++) Dout[8*i +: 8] <= nst[i];
              Dout_valid <= 1'b1;
              rnd        <= 4'd0;
              fsm        <= IDLE;
            end else begin
              rnd <= rnd + 4'd1;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Testbench for aes128_encrypt_core: directed FIPS vectors, stall, reset
// abort, back-to-back and random blocks against a byte-level AES model.
module tb_aes128_encrypt_core;
  localparam logic [0:127] K    = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [0:127] V1   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [0:127] C1   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [0:127] V2   = 128'h00112233445566778899AABBCCDDFFF0;
  localparam logic [0:127] C2   = 128'h1D3E80EAD35822D3C7694761104A8F87;
  localparam logic [0:127] CZ   = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, Din_valid, Dout_valid, Din0_valid, Dout0_valid;
  logic [0:127] Din, Dout, Din0, Dout0;
  int total = 0, passed = 0;
  logic [7:0] sbt [256];

  aes128_encrypt_core dut (.clk(clk), .reset(reset), .enable(enable), .Din(Din),
    .Din_valid(Din_valid), .Dout(Dout), .Dout_valid(Dout_valid));
  aes128_encrypt_core #(.KEY(128'h0)) dut0 (.clk(clk), .reset(reset), .enable(enable),
    .Din(Din0), .Din_valid(Din0_valid), .Dout(Dout0), .Dout_valid(Dout0_valid));

  // ---- reference model: S-box from GF(2^8) inverse + affine map ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbt[a] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] aes_ref(input logic [0:127] key, input logic [0:127] pt);
    logic [7:0] w [44][4];
    logic [7:0] tmp [4];
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] rc = 8'h01;
    logic [0:127] res;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[32*i+8*j +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbt[w[i-1][(j+1)%4]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[8*(4*c+r) +: 8] ^ w[c][r];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbt[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                    ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rd+c][r];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(4*c+r) +: 8] = s[r][c];
    return res;
  endfunction

  // ---- helpers ----
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic capture(input logic [0:127] d);
    Din = d; Din_valid = 1'b1;
    step();
    Din_valid = 1'b0; Din = rnd128();   // later Din changes must not matter
  endtask

  // wait (bounded) for the strobe; check latency, data and single-cycle pulse
  task automatic await_out(input string tag, input logic [0:127] exp, input int lat);
    int n = 0;
    while (Dout_valid !== 1'b1 && n < 40) begin step(); n++; end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_dout"}, Dout, exp);
    step();
    chk({tag, "_pulse"}, Dout_valid, 1'b0);
    chk({tag, "_hold"}, Dout, exp);
  endtask

  initial begin
    logic [0:127] q [$];
    logic [0:127] d, first;
    int pulses;
    build_sbox();
    chk("model_c1", aes_ref(K, V1), C1);

    reset = 1'b1; enable = 1'b1; Din_valid = 1'b0; Din0_valid = 1'b0;
    Din = '0; Din0 = '0;
    step();
    chk("rst_dout", Dout, '0);
    chk("rst_vld", Dout_valid, 1'b0);
    chk("rst_dout0", Dout0, '0);
    reset = 1'b0;
    step();
    chk("idle_vld", Dout_valid, 1'b0);

    // FIPS-197 C.1
    capture(V1);
    await_out("c1", C1, 10);

    // Din_valid held for two cycles -> one pulse only
    Din = V2; Din_valid = 1'b1;
    step(); step();
    Din_valid = 1'b0;
    pulses = 0; first = '0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (Dout_valid === 1'b1) begin
        if (pulses == 0) first = Dout;
        pulses++;
      end
    end
    chk("v2_pulses", pulses, 1);
    chk("v2_dout", first, C2);

    // zero-key instance
    Din0 = '0; Din0_valid = 1'b1;
    step();
    Din0_valid = 1'b0; Din0 = rnd128();
    for (int i = 0; i < 9; i++) begin
      step();
      chk("zk_early", Dout0_valid, 1'b0);
    end
    step();
    chk("zk_vld", Dout0_valid, 1'b1);
    chk("zk_dout", Dout0, CZ);

    // stall three cycles mid-run
    capture(V1);
    for (int i = 0; i < 4; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_vld", Dout_valid, 1'b0);
    end
    enable = 1'b1;
    await_out("stall", C1, 6);

    // reset while round 5 is pending aborts the block
    capture(V2);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_dout", Dout, '0);
    chk("abort_vld", Dout_valid, 1'b0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (Dout_valid === 1'b1) pulses++;
    end
    chk("abort_nopulse", pulses, 0);
    capture(V1);
    await_out("post_rst", C1, 10);

    // back-to-back: Din_valid held, Din changes every cycle
    pulses = 0;
    Din_valid = 1'b1;
    for (int e = 0; e < 55; e++) begin
      Din = rnd128();
      if (e % 11 == 0) q.push_back(aes_ref(K, Din));
      step();
      if (Dout_valid === 1'b1) begin
        pulses++;
        chk("b2b_phase", e % 11, 10);
        if (q.size() > 0) chk("b2b_dout", Dout, q.pop_front());
        else chk("b2b_extra", 1'b1, 1'b0);
      end
    end
    Din_valid = 1'b0;
    chk("b2b_pulses", pulses, 5);
    step();

    // random plaintexts against the model
    for (int k = 0; k < 8; k++) begin
      d = rnd128();
      capture(d);
      await_out("rand", aes_ref(K, d), 10);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
